// File: rtl/popcount_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : popcount_arb_pkg
// Description : Shared width helpers and response type for the popcount
//               arbiter and its tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package popcount_arb_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_NUM_REQ = 4;

  // Width of a requester ID; a single requester still needs one bit.
  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  // Width of a population count, sized to hold the all-ones value.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  localparam int unsigned DEF_ID_W  = id_width(DEF_NUM_REQ);
  localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_CNT_W-1:0] count;
  } resp_t;

endpackage
`default_nettype wire

// File: rtl/popcount_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : popcount_tag_fifo
// Description : In-order FIFO of requester IDs for words in flight inside the
//               shared counter. Push and pop in the same cycle are allowed
//               whenever the FIFO is non-empty, even when full.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_tag_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 2
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  // Next-state: pops only when data exists; a push into a full FIFO is legal
  // only when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & ((count_q != DEPTH_CNT) | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/popcount_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : popcount_arbiter
// Description : Round-robin arbiter sharing one bit population counter among
//               NUM_REQ requesters, returning each result tagged with the ID
//               of the requester that issued it.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_arbiter
  import popcount_arb_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data_i,
  input  logic [NUM_REQ-1:0]           req_val_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [WIDTH-1:0]             pc_data_o,
  output logic                         pc_data_val_o,
  input  logic [$clog2(WIDTH):0]       pc_data_i,
  input  logic                         pc_data_val_i,
  output logic [$clog2(WIDTH):0]       resp_data_o,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id_o,
  output logic                         resp_val_o,
  output logic                         err_o
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned OCC_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OCC_W-1:0] MAX_OCC = OCC_W'(MAX_OUTSTANDING);
  localparam logic [ID_W-1:0]  PTR_RST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] pc_data_q, pc_data_d;
  logic             pc_val_q, pc_val_d;
  logic [CNT_W-1:0] resp_data_q, resp_data_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic             resp_val_q, resp_val_d;
  logic             err_q, err_d;

  logic [ID_W-1:0]  tag_head;
  logic             tag_full, tag_empty;
  logic [OCC_W-1:0] tag_count;

  logic             pop;
  logic             credit_ok;
  logic             grant_any;
  logic             tag_push;
  logic [ID_W-1:0]  winner;
  int unsigned      cand;

  // Round-robin search from pointer+1, gated by credit; a returning result
  // frees its slot in the same cycle so full throughput is kept.
  always_comb begin
    pop         = pc_data_val_i & ~tag_empty & ~srst_i;
    credit_ok   = (tag_count < MAX_OCC) | pop;
    grant_any   = 1'b0;
    winner      = '0;
    cand        = 0;
    req_ready_o = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_any && req_val_i[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        winner    = cand[ID_W-1:0];
      end
    end
    if (srst_i || !credit_ok) begin
      grant_any = 1'b0;
    end
    if (grant_any) begin
      req_ready_o[winner] = 1'b1;
    end
    tag_push = grant_any & (~tag_full | pop);
  end

  // Next-state for issue, return and error registers.
  always_comb begin
    rr_ptr_d    = grant_any ? winner : rr_ptr_q;
    pc_val_d    = grant_any;
    pc_data_d   = grant_any ? req_data_i[32'(winner)*WIDTH +: WIDTH] : pc_data_q;
    resp_val_d  = pop;
    resp_data_d = pop ? pc_data_i : resp_data_q;
    resp_id_d   = pop ? tag_head : resp_id_q;
    err_d       = pc_data_val_i & tag_empty;
  end

  // Registered outputs and arbitration pointer; pointer resets so that
  // requester 0 has first priority.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rr_ptr_q    <= PTR_RST;
      pc_val_q    <= 1'b0;
      pc_data_q   <= '0;
      resp_val_q  <= 1'b0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      pc_val_q    <= pc_val_d;
      pc_data_q   <= pc_data_d;
      resp_val_q  <= resp_val_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      err_q       <= err_d;
    end
  end

  popcount_tag_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (ID_W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .push_i  (tag_push),
    .pop_i   (pop),
    .data_i  (winner),
    .head_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  assign pc_data_o     = pc_data_q;
  assign pc_data_val_o = pc_val_q;
  assign resp_data_o   = resp_data_q;
  assign resp_id_o     = resp_id_q;
  assign resp_val_o    = resp_val_q;
  assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_popcount_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount_arbiter
// Description : Self-checking bench for popcount_arbiter with a behavioural
//               counter of adjustable latency and a reference model of the
//               arbitration, credit and tagging rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_arbiter;
  import popcount_arb_pkg::*;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int M  = 4;
  localparam int CW = 5;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            srst;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_val;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    pc_data_out;
  logic            pc_val_out;
  logic [CW-1:0]   pc_data_in;
  logic            pc_val_in;
  logic [CW-1:0]   resp_data;
  logic [IW-1:0]   resp_id;
  logic            resp_val;
  logic            err;

  always #5 clk = ~clk;

  popcount_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_OUTSTANDING(M)) dut (
    .clk_i         (clk),
    .srst_i        (srst),
    .req_data_i    (req_data),
    .req_val_i     (req_val),
    .req_ready_o   (req_ready),
    .pc_data_o     (pc_data_out),
    .pc_data_val_o (pc_val_out),
    .pc_data_i     (pc_data_in),
    .pc_data_val_i (pc_val_in),
    .resp_data_o   (resp_data),
    .resp_id_o     (resp_id),
    .resp_val_o    (resp_val),
    .err_o         (err)
  );

  // Behavioural counter: delay line of (valid, popcount); latency = tap+1.
  logic [CW:0] pipe [16] = '{default: '0};
  logic [3:0]  tap  = 4'd1;
  logic        spur = 1'b0;
  always @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < 16; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {pc_val_out, CW'($countones(pc_data_out))};
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign pc_val_in  = spur | pipe[tap][CW];
  assign pc_data_in = spur ? CW'(7) : pipe[tap][CW-1:0];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int         mptr = N - 1;
  int         mout = 0;
  resp_t      sbq[$];
  resp_t      exp_resp;
  logic       exp_pcv = 1'b0;
  logic       exp_rv  = 1'b0;
  logic       exp_err = 1'b0;
  logic [W-1:0] exp_pcd = '0;
  logic [N-1:0] acc = '0;
  int         grant_log[$];
  int         dut_out = 0;
  int         max_out = 0;
  int         grant_pop = 0;

  // Monitor: check outputs against the model, then advance the model to the
  // upcoming clock edge using the inputs that edge will see.
  always @(negedge clk) begin
    logic [N-1:0] er;
    int  win;
    int  nxt;
    bit  pop_m;
    bit  hs;
    check_eq("pc_data_val", pc_val_out, exp_pcv);
    check_eq("pc_data", pc_data_out, exp_pcd);
    check_eq("resp_val", resp_val, exp_rv);
    if (exp_rv) begin
      check_eq("resp_id", resp_id, exp_resp.id);
      check_eq("resp_count", resp_data, exp_resp.count);
    end
    check_eq("err", err, exp_err);

    pop_m = pc_val_in && (mout > 0);
    win   = -1;
    if (!srst && (mout < M || pop_m)) begin
      for (int i = 1; i <= N; i++) begin
        if (win < 0 && req_val[(mptr + i) % N]) win = (mptr + i) % N;
      end
    end
    er = '0;
    if (win >= 0) er[win] = 1'b1;
    check_eq("req_ready", req_ready, er);

    hs = |(req_val & req_ready);
    if (srst) begin
      dut_out = 0;
    end else begin
      if (hs && pc_val_in && dut_out > 0) grant_pop++;
      nxt = dut_out + (hs ? 1 : 0) - ((pc_val_in && dut_out > 0) ? 1 : 0);
      dut_out = nxt;
      if (dut_out > max_out) max_out = dut_out;
    end

    if (srst) begin
      mptr = N - 1; mout = 0; sbq.delete();
      exp_pcv = 1'b0; exp_pcd = '0; exp_rv = 1'b0; exp_err = 1'b0;
    end else begin
      exp_err = pc_val_in && (mout == 0);
      exp_rv  = pop_m;
      if (pop_m) begin
        exp_resp = sbq.pop_front();
        mout--;
      end
      exp_pcv = (win >= 0);
      if (win >= 0) begin
        mptr    = win;
        exp_pcd = req_data[win*W +: W];
        sbq.push_back('{id: IW'(win), count: CW'($countones(req_data[win*W +: W]))});
        mout++;
        acc[win] = 1'b1;
        grant_log.push_back(win);
      end
    end
  end

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // Advance ncyc cycles; accepted requesters drop (or keep) their request and
  // idle requesters raise a new random word with probability prob percent.
  task automatic run(input int ncyc, input int prob, input bit keep);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #2;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          acc[k] = 1'b0;
          if (!keep) req_val[k] = 1'b0;
        end
      end
      if (prob > 0) begin
        for (int k = 0; k < N; k++) begin
          if (!req_val[k] && $urandom_range(0, 99) < prob) begin
            req_data[k*W +: W] = rand_word();
            req_val[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    srst = 1'b1;
    req_val = '0;
    @(posedge clk); #2;
    srst = 1'b0;
    acc = '0;
  endtask

  task automatic send_single(input int k, input logic [W-1:0] word, input int expcnt);
    int n = 0;
    bit got = 0;
    req_data[k*W +: W] = word;
    req_val[k] = 1'b1;
    while (!got && n < 40) begin
      @(posedge clk); #2;
      n++;
      if (acc[k]) begin acc[k] = 1'b0; req_val[k] = 1'b0; end
      if (resp_val) got = 1;
    end
    check_eq("single_seen", got, 1);
    check_eq("single_latency", n, int'(tap) + 3);
    check_eq("single_id", resp_id, k);
    check_eq("single_count", resp_data, expcnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; req_val = '1; req_data = '0;
    @(posedge clk); #2;
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_pc_val", pc_val_out, 0);
    check_eq("rst_pc_data", pc_data_out, 0);
    check_eq("rst_resp_val", resp_val, 0);
    check_eq("rst_resp_data", resp_data, 0);
    check_eq("rst_resp_id", resp_id, 0);
    check_eq("rst_err", err, 0);
    req_val = '0;
    srst = 1'b0;

    // Single request from requester 2, counter latency 2
    tap = 4'd1;
    send_single(2, 16'hE70F, 10);
    run(5, 0, 0);

    // All requesters continuously valid: strict rotation from requester 0
    do_reset();
    grant_log.delete();
    req_data = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
    req_val = '1;
    run(12, 0, 1);
    for (int i = 0; i < 8; i++) begin
      check_eq("rr_order", (grant_log.size() > i) ? grant_log[i] : 99, i % N);
    end
    req_val = '0;
    run(10, 0, 0);

    // Back-pressure with counter latency 8
    do_reset();
    tap = 4'd7;
    max_out = 0; grant_pop = 0;
    req_val = '1;
    run(6, 0, 1);
    check_eq("bp_ready_zero", req_ready, 0);
    run(30, 0, 1);
    req_val = '0;
    run(20, 0, 0);
    check_eq("bp_max_outstanding", max_out, M);
    check_eq("bp_grant_with_pop", grant_pop > 0, 1);

    // Boundary words
    tap = 4'd1;
    run(2, 0, 0);
    send_single(0, 16'h0000, 0);
    send_single(1, 16'hFFFF, 16);
    run(5, 0, 0);

    // Spurious counter result with nothing outstanding
    spur = 1'b1;
    @(posedge clk); #2;
    spur = 1'b0;
    check_eq("spur_err", err, 1);
    check_eq("spur_resp_val", resp_val, 0);
    @(posedge clk); #2;
    check_eq("spur_err_pulse", err, 0);
    send_single(3, 16'h00F0, 4);
    run(5, 0, 0);

    // Reset with three words in flight
    tap = 4'd7;
    req_data[0*W +: W] = 16'h1234; req_data[1*W +: W] = 16'h00FF; req_data[2*W +: W] = 16'h8001;
    req_val[2:0] = 3'b111;
    run(4, 0, 0);
    grant_log.delete();
    req_val[0] = 1'b1; req_val[3] = 1'b1;
    srst = 1'b1;
    #1;
    check_eq("mid_rst_ready", req_ready, 0);
    @(posedge clk); #2;
    check_eq("mid_rst_pc_val", pc_val_out, 0);
    check_eq("mid_rst_pc_data", pc_data_out, 0);
    check_eq("mid_rst_resp_val", resp_val, 0);
    check_eq("mid_rst_resp_data", resp_data, 0);
    check_eq("mid_rst_resp_id", resp_id, 0);
    check_eq("mid_rst_err", err, 0);
    srst = 1'b0;
    acc = '0;
    run(1, 0, 0);
    check_eq("post_rst_first", (grant_log.size() > 0) ? grant_log[0] : 99, 0);
    req_val = '0;
    run(20, 0, 0);

    // Randomized traffic over several counter latencies
    do_reset();
    for (int r = 0; r < 4; r++) begin
      tap = 4'($urandom_range(0, 6));
      run(150, (r % 2 == 0) ? 30 : 70, 0);
      req_val = '0;
      run(20, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/popcount_arbiter.md
Name: popcount_arbiter

Overview:
Shares one bit_population_counter instance between NUM_REQ requesters.
- Round-robin arbitration admits at most one request per clock into the counter.
- An in-order tag FIFO records the requester ID of every in-flight word.
- Each counter result is returned to its originating requester with that ID attached.
- Sits between the requester blocks and the counter. The arbiter drives the counter's data_i/data_val_i and consumes its data_o/data_val_o.

Parameters:
WIDTH, 16, data word width; must match the counter instance.
NUM_REQ, 4, number of requesters (>=2).
MAX_OUTSTANDING, 4, maximum words in flight inside the counter; tag FIFO depth; power of two.

Ports:
clk_i  input  1  clock
srst_i  input  1  synchronous reset, active-high
req_data_i  input  NUM_REQ*WIDTH  packed request words; requester k occupies bits [k*WIDTH +: WIDTH]
req_val_i  input  NUM_REQ  per-requester valid
req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high
pc_data_o  output  WIDTH  word to counter data_i
pc_data_val_o  output  1  to counter data_val_i
pc_data_i  input  $clog2(WIDTH)+1  counter data_o
pc_data_val_i  input  1  counter data_val_o
resp_data_o  output  $clog2(WIDTH)+1  popcount result
resp_id_o  output  $clog2(NUM_REQ)  requester ID of the result
resp_val_o  output  1  result valid, single-cycle pulse; no backpressure
err_o  output  1  single-cycle pulse: counter returned a result with no tag outstanding

Behaviour:
Reset:
- On srst_i=1, at the next edge: pc_data_val_o=0, pc_data_o=0, resp_val_o=0, resp_data_o=0, resp_id_o=0, err_o=0.
- Tag FIFO is emptied and the outstanding count is set to 0.
- RR pointer is set to NUM_REQ-1, so requester 0 has first priority.
- req_ready_o is all-zero while srst_i=1.

Handshake:
- A request is accepted in a cycle where req_val_i[k] & req_ready_o[k].
- req_ready_o is combinational from req_val_i, the RR pointer and credit.
- A requester holds its data stable and its valid high until accepted.
- req_ready_o[k] is never high unless req_val_i[k] is high.

Arbitration:
- Search starts at pointer+1 and wraps modulo NUM_REQ; the first valid requester wins.
- On a grant, the pointer updates to the winner's index. With no grant, the pointer is held.

Credit:
- A grant is allowed only if outstanding < MAX_OUTSTANDING, or a result returns in the same cycle (pop frees a slot).
- Outstanding count and FIFO stay consistent under simultaneous push and pop: count unchanged.

Issue:
- Accepted word is registered: pc_data_o = word and pc_data_val_o = 1 in the following cycle.
- Winner ID is pushed to the tag FIFO in the acceptance cycle.
- With no grant, pc_data_val_o = 0 and pc_data_o holds its last value.

Return:
- When pc_data_val_i=1 and the FIFO is non-empty, pop the head tag.
- Next cycle: resp_val_o=1, resp_data_o=pc_data_i, resp_id_o=tag.
- When pc_data_val_i=1 and the FIFO is empty, err_o pulses next cycle, resp_val_o stays 0, and state is unchanged.

Latency:
- Request accept edge to pc_data_val_o: 1 cycle.
- pc_data_val_i to resp_val_o: 1 cycle.
- End-to-end: 2 + counter latency.
- Full throughput: one word per cycle when MAX_OUTSTANDING >= counter latency + 2.

Ordering:
- Results return in issue order; the counter is in-order by construction.

Width rule:
- Result width is $clog2(WIDTH)+1 to hold the all-ones count. For WIDTH=16, 16'hFFFF -> 5'd16.

Reset mid-operation:
- In-flight tags are discarded.
- The counter shares srst_i, so no stale results arrive. Any that do raise err_o.

Decomposition:
Package popcount_arb_pkg:
- localparam helpers for ID width ($clog2(NUM_REQ)) and count width ($clog2(WIDTH)+1).
- typedef for the response struct {id, count}.

Sub-module popcount_tag_fifo:
- Synchronous FIFO, depth MAX_OUTSTANDING, data width ID_W.
- Ports: push, pop, full, empty, head, and a count output used for credit.
- Read-during-write is allowed when non-empty.

Round-robin grant logic stays inline in popcount_arbiter.

Test Plan:
1. Single request: requester 2 sends 16'hE70F -> accepted in 1 cycle; pc_data_val_o next cycle; resp_val_o with resp_data_o=10 and resp_id_o=2 after 2+counter latency cycles; err_o stays 0.
2. All 4 requesters valid continuously with distinct words (16'h0001, 16'h0003, 16'h0007, 16'h000F) -> grants in order 0,1,2,3,0,...; responses (id,count) = (0,1),(1,2),(2,3),(3,4) in issue order.
3. Back-pressure: counter latency stubbed to 8 cycles and MAX_OUTSTANDING=4 -> exactly 4 grants, then req_ready_o all-zero until the first result; a grant and a pop occur in the same cycle thereafter; outstanding never exceeds 4.
4. Boundary values: 16'h0000 -> 0; 16'hFFFF -> 16 (5'b10000).
5. Spurious return: drive pc_data_val_i=1 with the FIFO empty -> err_o one-cycle pulse, resp_val_o=0, next normal request still tagged correctly.
6. Reset mid-operation: srst_i=1 for 1 cycle with 3 words in flight -> all outputs zero, req_ready_o zero during reset; after release requester 0 wins first and no stale responses appear.
